riscv_str_unit: RTL and testbench
=================================

RISCV_STR_UNIT -- requirements
Module: riscv_str_unit

Interface
REQ-001 SHALL have parameter NBYTES, default 4: operand/result width in bytes; data width DW = 8*NBYTES.
REQ-002 SHALL have parameter LANES, default 1: bytes transformed per RUN cycle.
REQ-003 SHALL have parameter OP_WIDTH, default 2: operator field width, equal to STR_OP_WIDTH.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable_i  input  1  string instruction present in EX.
REQ-007 SHALL have port operator_i  input  OP_WIDTH  operation: STR_OP_UPPER=0, STR_OP_LOWER=1, STR_OP_LEET=2, STR_OP_ROT13=3.
REQ-008 SHALL have port operand_i  input  DW  source bytes; byte k = operand_i[8k+7:8k].
REQ-009 SHALL have port ex_ready_i  input  1  EX stage accepts the result this cycle.
REQ-010 SHALL have port result_o  output  DW  transformed bytes.
REQ-011 SHALL have port valid_o  output  1  result_o holds a completed result.
REQ-012 SHALL have port ready_o  output  1  unit not stalling EX.

Function
REQ-013 Parameter check: NBYTES>=1, 1<=LANES<=NBYTES, NBYTES%LANES==0; otherwise elaboration error.
REQ-014 FSM states IDLE, RUN, DONE; passes P = NBYTES/LANES.
REQ-015 IDLE with enable_i=1: capture operand_i into data register and operator_i into op register, chunk index=0, go to RUN.
REQ-016 RUN: each cycle replace bytes idx*LANES..idx*LANES+LANES-1 of data register with their transform, idx+1; after chunk P-1, go to DONE. Chunks proceed LSB first.
REQ-017 RUN lasts exactly P cycles; enable_i, operator_i, operand_i, ex_ready_i are ignored during RUN.
REQ-018 DONE: valid_o=1, result_o=data register; stay in DONE while ex_ready_i=0, result stable; with ex_ready_i=1 go to IDLE next edge, ignoring enable_i that cycle.
REQ-019 ready_o combinational: 1 in IDLE with enable_i=0, 0 in IDLE with enable_i=1, 0 in RUN, 1 in DONE.
REQ-020 result_o=0 and valid_o=0 in IDLE and RUN.
REQ-021 UPPER: bytes 0x61-0x7A minus 0x20; others unchanged.
REQ-022 LOWER: bytes 0x41-0x5A plus 0x20; others unchanged.
REQ-023 LEET, single pass, either case: E->0x33, S->0x35, L->0x31, O->0x30, A->0x34, T->0x37; others unchanged.
REQ-024 ROT13: letters rotate 13 within their own case, wrapping Z->M and z->m; non-letters unchanged.
REQ-025 Operator codes above 3 (OP_WIDTH>2): full RUN sequence, bytes unchanged.
REQ-026 All byte arithmetic SHALL be 8-bit, no carry between bytes; range bounds inclusive.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, data register 0, op register 0, idx 0, valid_o=0, result_o=0; ready_o follows REQ-019.
REQ-028 Reset asserted in RUN or DONE SHALL abandon the operation with no residual effect; the first post-reset operation SHALL be correct.

Verification
REQ-029 NBYTES=4, LANES=1, UPPER, operand 0x7B7A6261 -> result 0x7B5A4241; ready_o low 5 cycles (accept + 4 RUN); valid_o high on 6th.
REQ-030 ROT13, operand 0x615A6E4D -> result 0x6E4D615A (wrap at Z/n checked).
REQ-031 LEET, operand 0x21534C65 -> result 0x21353133.
REQ-032 LANES=4, LOWER, operand 0x40216948 -> result 0x40216968; valid_o high 2 edges after accept (0x40 boundary unchanged).
REQ-033 DONE with ex_ready_i=0 for 3 cycles -> valid_o and result_o stable; ex_ready_i=1 -> next cycle IDLE, valid_o=0, result_o=0.
REQ-034 rst_n low during 2nd RUN cycle -> outputs 0, ready_o=1 with enable_i=0; next UPPER op 0x00000061 -> 0x00000041.

Source files
------------

// File: rtl/riscv_str_unit.sv
// String transform unit for the EX stage: upper/lower case, leet and rot13 on the
// operand bytes, LANES bytes per cycle, result held until EX accepts it.
module riscv_str_unit #(
  parameter int NBYTES   = 4,
  parameter int LANES    = 1,
  parameter int OP_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [OP_WIDTH-1:0]   operator_i,
  input  logic [8*NBYTES-1:0]   operand_i,
  input  logic                  ex_ready_i,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  valid_o,
  output logic                  ready_o
);

  localparam int DW = 8 * NBYTES;
  localparam int P  = (LANES > 0) ? (NBYTES / LANES) : 1;
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

  localparam logic [OP_WIDTH-1:0] STR_OP_UPPER = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] STR_OP_LOWER = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] STR_OP_LEET  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] STR_OP_ROT13 = OP_WIDTH'(3);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (NBYTES < 1 || LANES < 1 || LANES > NBYTES || (NBYTES % LANES) != 0) begin : g_bad_params
      $error("riscv_str_unit: illegal NBYTES/LANES combination");
    end
  endgenerate

  logic [1:0]          state_q;
  logic [DW-1:0]       data_q;
  logic [DW-1:0]       data_next;
  logic [OP_WIDTH-1:0] op_q;
  logic [IW-1:0]       idx_q;

  function automatic logic [7:0] xform(input logic [OP_WIDTH-1:0] op, input logic [7:0] b);
    logic [7:0] r;
    r = b;
    case (op)
      STR_OP_UPPER: if (b >= 8'h61 && b <= 8'h7a) r = b - 8'h20;
      STR_OP_LOWER: if (b >= 8'h41 && b <= 8'h5a) r = b + 8'h20;
      STR_OP_LEET: begin
        case (b)
          8'h45, 8'h65: r = 8'h33;
          8'h53, 8'h73: r = 8'h35;
          8'h4c, 8'h6c: r = 8'h31;
          8'h4f, 8'h6f: r = 8'h30;
          8'h41, 8'h61: r = 8'h34;
          8'h54, 8'h74: r = 8'h37;
          default:      r = b;
        endcase
      end
      STR_OP_ROT13: begin
        // First half of each alphabet moves up 13, second half moves down 13.
        if ((b >= 8'h41 && b <= 8'h4d) || (b >= 8'h61 && b <= 8'h6d))
          r = b + 8'd13;
        else if ((b >= 8'h4e && b <= 8'h5a) || (b >= 8'h6e && b <= 8'h7a))
          r = b - 8'd13;
      end
      default: r = b;
    endcase
    return r;
  endfunction

  // Transform only the chunk selected by idx_q; the rest of the register is kept.
  always_comb begin
    data_next = data_q;
    for (int k = 0; k < NBYTES; k++) begin
      if ((k / LANES) == int'(idx_q))
        data_next[8*k +: 8] = xform(op_q, data_q[8*k +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      op_q    <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            data_q  <= operand_i;
            op_q    <= operator_i;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          data_q <= data_next;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          if (ex_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Handshake: valid_o marks a finished result, held stable until ex_ready_i is
  // sampled high in DONE; ready_o low means EX must stall on this instruction.
  always_comb begin
    valid_o  = 1'b0;
    result_o = '0;
    ready_o  = 1'b1;
    case (state_q)
      S_IDLE: ready_o = ~enable_i;
      S_RUN:  ready_o = 1'b0;
      S_DONE: begin
        valid_o  = 1'b1;
        result_o = data_q;
        ready_o  = 1'b1;
      end
      default: ready_o = ~enable_i;
    endcase
  end

endmodule

// File: tb/tb_riscv_str_unit.sv
// Bench for riscv_str_unit: one-lane and four-lane instances on shared inputs,
// directed vectors plus random operations scored against a byte-level model.
module tb_riscv_str_unit;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          ex_ready;
  logic [1:0]    op;
  logic [DW-1:0] operand;
  logic [DW-1:0] res1, res4;
  logic          v1, v4, r1, r4;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  riscv_str_unit #(.NBYTES(4), .LANES(1), .OP_WIDTH(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op), .operand_i(operand),
    .ex_ready_i(ex_ready), .result_o(res1), .valid_o(v1), .ready_o(r1)
  );

  riscv_str_unit #(.NBYTES(4), .LANES(4), .OP_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .operator_i(op), .operand_i(operand),
    .ex_ready_i(ex_ready), .result_o(res4), .valid_o(v4), .ready_o(r4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int o, input logic [7:0] b);
    int c;
    int f;
    bit up;
    bit lo;
    c  = int'(b);
    up = (c >= 65 && c <= 90);
    lo = (c >= 97 && c <= 122);
    case (o)
      0: if (lo) return 8'(c - 32);
      1: if (up) return 8'(c + 32);
      2: begin
        f = lo ? c - 32 : c;
        if (f == 69) return 8'h33;
        if (f == 83) return 8'h35;
        if (f == 76) return 8'h31;
        if (f == 79) return 8'h30;
        if (f == 65) return 8'h34;
        if (f == 84) return 8'h37;
      end
      3: begin
        if (up) return 8'(65 + (c - 65 + 13) % 26);
        if (lo) return 8'(97 + (c - 97 + 13) % 26);
      end
      default: ;
    endcase
    return b;
  endfunction

  function automatic logic [DW-1:0] ref_word(input int o, input logic [DW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_byte(o, a[8*k +: 8]);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_v1"}, v1, 0);
    check({tag, "_res1"}, res1, 0);
    check({tag, "_r1"}, r1, 1);
    check({tag, "_v4"}, v4, 0);
    check({tag, "_res4"}, res4, 0);
    check({tag, "_r4"}, r4, 1);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [DW-1:0] a, input int stall);
    logic [DW-1:0] exp;
    @(negedge clk);
    enable = 1'b1; op = o; operand = a; ex_ready = 1'b0;
    #1;
    check("ready1_accept", r1, 0);
    check("ready4_accept", r4, 0);
    exp_q.push_back(ref_word(int'(o), a));
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      enable = 1'($urandom_range(0, 1)); op = 2'($urandom); operand = $urandom;
      #1;
      check("valid1_lat", v1, n == 5);
      check("ready1_lat", r1, n == 5);
      check("valid4_lat", v4, n >= 2);
      check("ready4_lat", r4, n >= 2);
    end
    exp = exp_q.pop_front();
    check("result1", res1, exp);
    check("result4", res4, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      enable = 1'($urandom_range(0, 1));
      #1;
      check("stall_v1", v1, 1);
      check("stall_res1", res1, exp);
      check("stall_res4", res4, exp);
    end
    @(negedge clk);
    ex_ready = 1'b1; enable = 1'($urandom_range(0, 1));
    @(negedge clk);
    ex_ready = 1'b0; enable = 1'b0;
    #1;
    check_idle("release");
  endtask

  initial begin
    logic [DW-1:0] a;
    rst_n = 1'b0; enable = 1'b0; ex_ready = 1'b0; op = 2'd0; operand = '0;
    #12;
    check_idle("reset");
    enable = 1'b1;
    #1;
    check("reset_r1_en", r1, 0);
    check("reset_r4_en", r4, 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'd0, 32'h7B7A6261, 3);
    do_op(2'd3, 32'h615A6E4D, 0);
    do_op(2'd2, 32'h21534C65, 1);
    do_op(2'd1, 32'h40216948, 2);

    // Reset in the second RUN cycle of the one-lane instance.
    @(negedge clk);
    enable = 1'b1; op = 2'd0; operand = 32'h61626364;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'd0, 32'h00000061, 0);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < 4; k++)
        a[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h3f, 8'h7b));
      do_op(2'($urandom_range(0, 3)), a, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
